mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle control sequencer that drives the datapath (yIF/yPC/yID/yEX/yDM/yWB) in place of testbench-driven control. It latches each fetched instruction, decodes opcode/funct, and steps through FETCH/DECODE/EXEC/MEM/WB. Each state issues the RegDst/RegWrite/ALUSrc/op/Mem2Reg/MemRead/MemWrite/branch/jump/INT signals. A single PC-write strobe per instruction advances the PC. Supported instructions are add, or, addi, lw, sw, beq and j. Any other opcode halts the machine with an error flag.

## Interface
- ENTRY_POINT, 128: address presented on `entry_point` while `int_o` is high.
- MAX_INS, 0: number of instructions to retire before entering HALT; 0 means unlimited.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ins  in  32  instruction from yIF; sampled only in FETCH when `ir_write`=1.
- zero  in  1  ALU zero flag from yEX; consumed by yPC, not by this block.
- stall  in  1  when 1 in FETCH: hold FETCH, no `ir_write`.
- int_o  out  1  INT to yPC; selects `entry_point` as next PC.
- entry_point  out  32  constant ENTRY_POINT.
- ir_write  out  1  instruction latch enable.
- pc_write  out  1  one-cycle PC update strobe per instruction.
- reg_dst, reg_write, alu_src, mem2reg, mem_read, mem_write, branch, jump  out  1 each  datapath controls.
- alu_op  out  3  ALU operation: ADD=010, OR=001, SUB=110.
- state  out  3  current state encoding, for debug.
- retired  out  32  count of completed instructions.
- illegal  out  1  sticky: unsupported opcode/funct decoded.
- done  out  1  high in HALT.

## Operation
- States: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- On reset:
  - state=BOOT, int_o=1, retired=0, illegal=0.
  - All other control outputs 0; alu_op=010.
- BOOT: int_o=1 and pc_write=1 (PC loads ENTRY_POINT); next state FETCH.
- FETCH:
  - stall=0: ir_write=1, the internal IR latches `ins`, next state DECODE.
  - stall=1: stay in FETCH with ir_write=0.
- DECODE: classify the latched IR.
  - j (op 2): jump=1, pc_write=1, retire, next FETCH.
  - Unsupported: illegal set, next HALT, no retire.
  - All others: next EXEC.
- EXEC, per class:
  - R add (op 0, funct 20h) / R or (funct 25h): alu_src=0, alu_op=ADD / OR; next WB.
  - addi (op 8): alu_src=1, alu_op=ADD; next WB.
  - lw (op 23h) / sw (op 2Bh): alu_src=1, alu_op=ADD; next MEM.
  - beq (op 4): alu_src=0, alu_op=SUB, branch=1, pc_write=1, retire; next FETCH.
- MEM: alu_src=1, alu_op=ADD held.
  - lw: mem_read=1; next WB.
  - sw: mem_write=1, pc_write=1, retire; next FETCH.
- WB: reg_write=1, pc_write=1, retire; next FETCH.
  - R-type: reg_dst=1, alu_src=0; R-type alu_op held from EXEC.
  - addi: reg_dst=0, alu_src=1, alu_op=ADD held from EXEC.
  - lw: reg_dst=0, mem2reg=1, mem_read=1, alu_src=1, alu_op=ADD held.
- Any control not listed for a state is 0; alu_op defaults to ADD.
- Retire means `retired` increments on that clock edge.
  - If MAX_INS≠0 and the post-increment count equals MAX_INS, the next state is HALT instead of FETCH.
- HALT: done=1, all enables 0; sticky until rst_n low.
- `retired` wraps modulo 2^32.

## Timing
- Controls are Moore outputs: they are decoded from the registered state and IR, and are valid for the whole state cycle.
- Instruction latency from FETCH entry (no stall): j 2, beq 3, add/or/addi/sw 4, lw 5 cycles.
- pc_write is high exactly once per retired instruction, in its final state. It is never high in FETCH, DECODE (except j), or HALT.
- Stall is only honoured in FETCH; it is ignored in all other states.
- Asynchronous reset mid-instruction aborts it immediately. The aborted instruction is not retired and its writes are not issued after reset.
- illegal and done rise in the cycle HALT is entered (after the DECODE edge).

## Structure
- Package `mc_ctrl_pkg`:
  - State enum.
  - Opcode constants: R=0, J=2, BEQ=4, ADDI=8, LW=23h, SW=2Bh.
  - Funct constants: ADD=20h, OR=25h.
  - ALU op constants.
  - Instruction-class enum: R_ADD, R_OR, ADDI, LW, SW, BEQ, J, BAD.
- Sub-module `mc_ins_class`: combinational opcode/funct → class decoder. The FSM and output decode live in the top.

## Test plan
- Reset, then release with stall=0: one cycle of int_o=1/pc_write=1 with entry_point=128, then state=FETCH.
- Sequence add, or, addi, lw, sw, beq, j:
  - pc_write pulse spacing is 4, 4, 4, 5, 4, 3, 2 cycles.
  - retired reaches 7.
  - lw WB shows mem2reg=1, reg_write=1.
  - beq EXEC shows alu_op=110, branch=1.
- Hold stall=1 for 5 cycles in FETCH: state stays 1, ir_write=0, retired unchanged; stall=0 resumes with ir_write=1.
- Opcode 3Fh: DECODE → HALT, illegal=1, done=1, retired unchanged; outputs stay 0 for 10 further cycles.
- MAX_INS=3 with three addi: done=1 immediately after the third WB, and retired=3.
- Assert rst_n=0 in lw MEM: outputs return to reset values asynchronously, retired=0, no reg_write pulse follows.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_OR   = 6'h25;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [2:0] {
    IC_R_ADD,
    IC_R_OR,
    IC_ADDI,
    IC_LW,
    IC_SW,
    IC_BEQ,
    IC_J,
    IC_BAD
  } ins_class_t;

endpackage

// File: rtl/mc_ins_class.sv
// Combinational opcode/funct classifier; anything unrecognised maps to IC_BAD.
module mc_ins_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output ins_class_t  cls
);

  always_comb begin
    cls = IC_BAD;
    case (op)
      OP_R: begin
        if (funct == FN_ADD)     cls = IC_R_ADD;
        else if (funct == FN_OR) cls = IC_R_OR;
      end
      OP_J:    cls = IC_J;
      OP_BEQ:  cls = IC_BEQ;
      OP_ADDI: cls = IC_ADDI;
      OP_LW:   cls = IC_LW;
      OP_SW:   cls = IC_SW;
      default: cls = IC_BAD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer producing Moore datapath
// controls from the registered state and the latched instruction.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter logic [31:0] ENTRY_POINT = 32'd128,
  parameter int unsigned MAX_INS     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        stall,
  output logic        int_o,
  output logic [31:0] entry_point,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem2reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        illegal,
  output logic        done
);

  localparam logic [31:0] MAX_LIM = 32'(MAX_INS);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] ir;
  ins_class_t  cls;
  logic        retire;
  logic        set_illegal;
  logic        limit_hit;

  // zero is consumed by yPC; only opcode and funct of the IR matter here.
  logic unused;
  assign unused = ^{zero, ir[25:6]};

  mc_ins_class u_class (
    .op    (ir[31:26]),
    .funct (ir[5:0]),
    .cls   (cls)
  );

  assign limit_hit   = (MAX_LIM != 32'd0) && ((retired + 32'd1) == MAX_LIM);
  assign entry_point = ENTRY_POINT;
  assign state       = state_q;
  assign done        = (state_q == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      retired <= 32'd0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)      retired <= retired + 32'd1;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  // The IR is pure data: it is only ever read after a FETCH has loaded it.
  always_ff @(posedge clk) begin
    if (ir_write) ir <= ins;
  end

  always_comb begin
    state_d     = state_q;
    int_o       = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    mem2reg     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_op      = ALU_ADD;
    retire      = 1'b0;
    set_illegal = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // Suppress the PC strobe while reset is still held.
        int_o    = 1'b1;
        pc_write = rst_n;
        state_d  = ST_FETCH;
      end
      ST_FETCH: begin
        if (!stall) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (cls)
          IC_J: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          IC_BAD: begin
            set_illegal = 1'b1;
            state_d     = ST_HALT;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls)
          IC_R_ADD: state_d = ST_WB;
          IC_R_OR: begin
            alu_op  = ALU_OR;
            state_d = ST_WB;
          end
          IC_ADDI: begin
            alu_src = 1'b1;
            state_d = ST_WB;
          end
          IC_LW, IC_SW: begin
            alu_src = 1'b1;
            state_d = ST_MEM;
          end
          IC_BEQ: begin
            alu_op   = ALU_SUB;
            branch   = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          default: state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        alu_src = 1'b1;
        if (cls == IC_LW) begin
          mem_read = 1'b1;
          state_d  = ST_WB;
        end else begin
          mem_write = 1'b1;
          pc_write  = 1'b1;
          retire    = 1'b1;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        case (cls)
          IC_R_ADD: reg_dst = 1'b1;
          IC_R_OR: begin
            reg_dst = 1'b1;
            alu_op  = ALU_OR;
          end
          IC_ADDI: alu_src = 1'b1;
          IC_LW: begin
            mem2reg  = 1'b1;
            mem_read = 1'b1;
            alu_src  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    if (retire) state_d = limit_hit ? ST_HALT : ST_FETCH;
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: instruction sequence, stall, illegal, limit, reset abort.
module tb_mc_ctrl_fsm;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_OR   = 32'h00221825;
  localparam logic [31:0] I_ADDI = 32'h20220005;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BEQ  = 32'h10220002;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, zero;
  logic [31:0] ins;
  logic        int_o, ir_write, pc_write, reg_dst, reg_write, alu_src, mem2reg;
  logic        mem_read, mem_write, branch, jump, illegal, done;
  logic [2:0]  alu_op, state;
  logic [31:0] entry_point, retired;

  logic        rst_m, stall_m;
  logic [31:0] ins_m;
  logic        int_m, ir_write_m, pc_write_m, reg_dst_m, reg_write_m, alu_src_m, mem2reg_m;
  logic        mem_read_m, mem_write_m, branch_m, jump_m, illegal_m, done_m;
  logic [2:0]  alu_op_m, state_m;
  logic [31:0] entry_point_m, retired_m;

  int n_chk  = 0;
  int n_pass = 0;

  mc_ctrl_fsm #(.ENTRY_POINT(32'd128), .MAX_INS(0)) dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero), .stall(stall),
    .int_o(int_o), .entry_point(entry_point), .ir_write(ir_write), .pc_write(pc_write),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src), .mem2reg(mem2reg),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .alu_op(alu_op), .state(state), .retired(retired), .illegal(illegal), .done(done)
  );

  mc_ctrl_fsm #(.ENTRY_POINT(32'd128), .MAX_INS(3)) dut_m (
    .clk(clk), .rst_n(rst_m), .ins(ins_m), .zero(zero), .stall(stall_m),
    .int_o(int_m), .entry_point(entry_point_m), .ir_write(ir_write_m), .pc_write(pc_write_m),
    .reg_dst(reg_dst_m), .reg_write(reg_write_m), .alu_src(alu_src_m), .mem2reg(mem2reg_m),
    .mem_read(mem_read_m), .mem_write(mem_write_m), .branch(branch_m), .jump(jump_m),
    .alu_op(alu_op_m), .state(state_m), .retired(retired_m), .illegal(illegal_m), .done(done_m)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the FETCH cycle; returns in the cycle pc_write is seen.
  task automatic to_pulse(input logic [31:0] i, input int lat, input string tag);
    int n;
    ins = i;
    n = 1;
    while (pc_write !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal;
  end

  initial begin
    logic seen;
    logic [2:0] prev;
    int cyc;

    rst_n = 1'b0; stall = 1'b0; zero = 1'b0; ins = 32'd0;
    rst_m = 1'b0; stall_m = 1'b0; ins_m = I_ADDI;

    tick();
    chk("rst_state", state, 0);
    chk("rst_int", int_o, 1);
    chk("rst_pcw", pc_write, 0);
    chk("rst_retired", retired, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_aluop", alu_op, 3'b010);

    rst_n = 1'b1;
    #1;
    chk("boot_int", int_o, 1);
    chk("boot_pcw", pc_write, 1);
    chk("boot_entry", entry_point, 128);
    tick();
    chk("fetch_state", state, 1);
    chk("fetch_irw", ir_write, 1);

    to_pulse(I_ADD, 4, "add");   tick();
    to_pulse(I_OR, 4, "or");     tick();
    to_pulse(I_ADDI, 4, "addi"); tick();
    to_pulse(I_LW, 5, "lw");
    chk("lw_mem2reg", mem2reg, 1);
    chk("lw_regwrite", reg_write, 1);
    chk("lw_regdst", reg_dst, 0);
    tick();
    to_pulse(I_SW, 4, "sw");
    chk("sw_memwrite", mem_write, 1);
    tick();
    to_pulse(I_BEQ, 3, "beq");
    chk("beq_aluop", alu_op, 3'b110);
    chk("beq_branch", branch, 1);
    tick();
    to_pulse(I_J, 2, "j");
    chk("j_jump", jump, 1);
    tick();
    chk("seq_retired", retired, 7);
    chk("seq_state", state, 1);

    ins = I_ADDI;
    stall = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_state", state, 1);
      chk("stall_irw", ir_write, 0);
      tick();
    end
    chk("stall_retired", retired, 7);
    stall = 1'b0;
    #1;
    chk("resume_irw", ir_write, 1);
    to_pulse(I_ADDI, 4, "addi2");
    tick();
    chk("addi2_retired", retired, 8);

    ins = I_BAD;
    tick();
    chk("bad_decode", state, 2);
    tick();
    chk("bad_halt", state, 6);
    chk("bad_illegal", illegal, 1);
    chk("bad_done", done, 1);
    chk("bad_retired", retired, 8);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("halt_quiet", {int_o, ir_write, pc_write, reg_dst, reg_write, alu_src, mem2reg,
                         mem_read, mem_write, branch, jump, done}, 12'h001);
    end

    rst_n = 1'b0;
    #1;
    chk("rst2_illegal", illegal, 0);
    ins = I_LW;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("abort_mem_state", state, 4);
    chk("abort_mem_read", mem_read, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", state, 0);
    chk("abort_int", int_o, 1);
    chk("abort_mem_read0", mem_read, 0);
    chk("abort_pcw", pc_write, 0);
    chk("abort_retired", retired, 0);
    stall = 1'b1;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen = seen | reg_write;
      tick();
    end
    chk("abort_no_regwrite", seen, 0);
    chk("abort_stalled", state, 1);

    rst_m = 1'b1;
    #1;
    cyc = 0;
    prev = state_m;
    while (done_m !== 1'b1 && cyc < 40) begin
      prev = state_m;
      tick();
      cyc++;
    end
    chk("max_cycles", cyc, 13);
    chk("max_prev_wb", prev, 5);
    chk("max_retired", retired_m, 3);
    chk("max_illegal", illegal_m, 0);
    chk("max_entry", entry_point_m, 128);
    tick();
    chk("max_sticky", {done_m, state_m}, 4'b1110);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
